// File: rtl/model_net.sv
// model_net: fixed-weight quantised inference core.
// 64 signed samples -> conv2 (4 taps, stride 4) -> act3 ReLU/requant ->
// dense5 (16x16, banded) -> act6 ReLU/requant -> 16 unsigned scores.
// All arithmetic is combinational; scores are registered on the en strobe.
// Optional build macro MODEL_NET_PIPE_EN adds a register on the act3 outputs,
// giving a latency of 2 edges instead of 1.
module model_net #(
    parameter int XD      = 64,
    parameter int XB      = 11,
    parameter int YD      = 16,
    parameter int YB      = 10,
    parameter int K2      = 4,
    parameter int WB      = 8,
    parameter int AB      = 8,
    parameter int SHIFT3  = 4,
    parameter int SHIFT6  = 0,
    parameter int W5_DIAG = 1,
    parameter int W5_NEXT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [XD*XB-1:0]   x,
    output logic [YD*YB-1:0]   y
);

    // Accumulator widths: conv2 peaks at 10*1024, dense5 at a few thousand.
    localparam int CW = 22;
    localparam int DW = 21;

    localparam logic signed [WB-1:0] W2 [4] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    localparam logic signed [CW-1:0] B2 = '0;
    localparam logic signed [DW-1:0] B5 = '0;

    // dense5 weight table: diagonal plus the next (circular) neighbour.
    function automatic logic signed [WB-1:0] w5(input int o, input int i);
        if (i == o)
            return WB'(W5_DIAG);
        else if (i == (o + 1) % YD)
            return WB'(W5_NEXT);
        else
            return '0;
    endfunction

    // ReLU, right shift, clamp to an unsigned AB-bit activation.
    function automatic logic [AB-1:0] sat_u8(input logic signed [CW-1:0] v);
        logic signed [CW-1:0] r;
        r = (v < 0) ? '0 : v;
        r = r >>> SHIFT3;
        if (|r[CW-1:AB])
            return '1;
        else
            return r[AB-1:0];
    endfunction

    // ReLU, right shift, clamp to an unsigned YB-bit score.
    function automatic logic [YB-1:0] sat_u10(input logic signed [DW-1:0] v);
        logic signed [DW-1:0] r;
        r = (v < 0) ? '0 : v;
        r = r >>> SHIFT6;
        if (|r[DW-1:YB])
            return '1;
        else
            return r[YB-1:0];
    endfunction

    logic [YD-1:0][AB-1:0] act3_a;
    logic [YD-1:0][AB-1:0] dense_src;
    logic [YD-1:0][YB-1:0] act6_y_d;
    logic [YD-1:0][YB-1:0] act6_y_q;
    logic                  load_y;

    // conv2 + act3: non-overlapping 4-tap windows, one per output channel.
    always_comb begin
        logic signed [CW-1:0] acc;
        logic signed [XB-1:0] xs;
        act3_a = '0;
        for (int j = 0; j < YD; j++) begin
            acc = B2;
            for (int k = 0; k < K2; k++) begin
                xs  = x[(K2*j+k)*XB +: XB];
                acc = acc + CW'(W2[k]) * CW'(xs);
            end
            act3_a[j] = sat_u8(acc);
        end
    end

`ifdef MODEL_NET_PIPE_EN
    logic [YD-1:0][AB-1:0] act3_a_q;
    logic                  vld_p1_q;

    // Stage 1: hold the activations and a delayed strobe for the dense stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            act3_a_q <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= en;
            if (en)
                act3_a_q <= act3_a;
        end
    end

    assign dense_src = act3_a_q;
    assign load_y    = vld_p1_q;
`else
    assign dense_src = act3_a;
    assign load_y    = en;
`endif

    // dense5 + act6: banded matrix-vector product, then score requant.
    always_comb begin
        logic signed [DW-1:0] acc;
        act6_y_d = '0;
        for (int o = 0; o < YD; o++) begin
            acc = B5;
            for (int i = 0; i < YD; i++)
                acc = acc + DW'(w5(o, i)) * signed'(DW'(dense_src[i]));
            act6_y_d[o] = sat_u10(acc);
        end
    end

    // Output register: cleared by rst, loaded on the (possibly delayed) strobe.
    always_ff @(posedge clk) begin
        if (rst)
            act6_y_q <= '0;
        else if (load_y)
            act6_y_q <= act6_y_d;
    end

    assign y = act6_y_q;

endmodule

// File: tb/tb_model_net.sv
module tb_model_net;
    localparam int XD = 64;
    localparam int XB = 11;
    localparam int YD = 16;
    localparam int YB = 10;
`ifdef MODEL_NET_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                clk;
    logic                rst;
    logic                en;
    logic [XD*XB-1:0]    x;
    logic [YD*YB-1:0]    y;
    logic [YD*YB-1:0]    y_w4;
    logic [YD*YB-1:0]    y_s0;

    int vectors;
    int miscompares;

    model_net dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y)
    );

    model_net #(.W5_DIAG(4)) dut_w4 (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y_w4)
    );

    model_net #(.SHIFT3(0)) dut_s0 (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y_s0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XD*XB-1:0] fill_x(input int v);
        logic [XD*XB-1:0] r;
        for (int n = 0; n < XD; n++)
            r[n*XB +: XB] = XB'(v);
        return r;
    endfunction

    function automatic logic [YD*YB-1:0] fill_y(input int v);
        logic [YD*YB-1:0] r;
        for (int o = 0; o < YD; o++)
            r[o*YB +: YB] = YB'(v);
        return r;
    endfunction

    function automatic logic [YD*YB-1:0] two_y(input int v0, input int v1);
        logic [YD*YB-1:0] r;
        r = '0;
        r[0*YB +: YB] = YB'(v0);
        r[1*YB +: YB] = YB'(v1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [YD*YB-1:0] obs,
                         input logic [YD*YB-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a frame, pulse en for one edge, wait out the latency.
    task automatic frame(input logic [XD*XB-1:0] xv);
        x  = xv;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (LAT - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        en  = 1'b0;
        x   = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_y", y, fill_y(0));
        check("reset_y_w4", y_w4, fill_y(0));
        check("reset_y_s0", y_s0, fill_y(0));
        rst = 1'b0;

        // All x = 16: c=160, a=10, y=10+20=30.
        x  = fill_x(16);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
`ifdef MODEL_NET_PIPE_EN
        check("pipe_first_edge_y", y, fill_y(0));
        @(posedge clk);
        #1;
`endif
        check("all16_y", y, fill_y(30));
        check("all16_w4", y_w4, fill_y(60));
        check("all16_s0", y_s0, fill_y(480));

        x = fill_x(7);
        repeat (2) @(posedge clk);
        #1;
        check("all16_hold", y, fill_y(30));

        // Negative input: ReLU floors everything to zero.
        frame(fill_x(-5));
        check("neg5_y", y, fill_y(0));
        check("neg5_s0", y_s0, fill_y(0));

        // Saturation: a clamps to 255, y=765; diag=4 pushes y past 1023.
        frame(fill_x(1023));
        check("sat_y", y, fill_y(765));
        check("sat_s0", y_s0, fill_y(765));
        check("sat_w4_clamp", y_w4, fill_y(1023));

        // Single hot sample x[4]=160 lands in channel 1.
        begin
            logic [XD*XB-1:0] xv;
            xv = '0;
            xv[4*XB +: XB] = 11'd160;
            frame(xv);
        end
        check("hot_y", y, two_y(20, 10));
        check("hot_w4", y_w4, two_y(20, 40));
        check("hot_s0", y_s0, two_y(320, 160));

        // Back-to-back strobes: each edge captures the then-current x.
        frame(fill_x(16));
        frame(fill_x(32));
        check("b2b_y", y, fill_y(60));

        // rst coincident with en: reset wins, y stays 0.
        x   = fill_x(16);
        rst = 1'b1;
        en  = 1'b1;
        @(posedge clk);
        #1;
        check("rst_en_y", y, fill_y(0));
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en_after", y, fill_y(0));
        check("rst_en_after_w4", y_w4, fill_y(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
